// File: rtl/csr_bank_if.sv
// Request/response channels between the AXI-Lite slave FSM (master) and csr_bank (slave).
interface csr_bank_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_resp_valid;
  logic                    wr_resp_ready;
  logic [1:0]              wr_resp;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_data_valid;
  logic                    rd_data_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, wr_resp_ready,
    output rd_valid, rd_addr, rd_data_ready,
    input  wr_ready, wr_resp_valid, wr_resp,
    input  rd_ready, rd_data_valid, rd_data, rd_resp
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, wr_resp_ready,
    input  rd_valid, rd_addr, rd_data_ready,
    output wr_ready, wr_resp_valid, wr_resp,
    output rd_ready, rd_data_valid, rd_data, rd_resp
  );
endinterface

// File: rtl/csr_bank.sv
// Parametrised CSR bank: RW / RO-status / W1C-sticky registers behind independent
// write (two-state FSM, one outstanding) and read (one-entry output register) channels.
module csr_bank #(
  parameter int                DATA_WIDTH = 32,
  parameter int                NUM_REGS   = 16,
  parameter int                ADDR_WIDTH = 6,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  csr_bank_if.slave                            bus,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_hw_in,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  o_regs_out
);

  typedef enum logic {S_IDLE, S_RESP} wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  wr_state_t                          r_wr_state, w_wr_state_nxt;
  logic [1:0]                         r_wr_resp, w_wr_resp;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs, w_regs_nxt;
  logic [NUM_REGS-1:0]                w_wr_sel;
  logic [DATA_WIDTH-1:0]              w_bmask;
  logic                               w_wr_acc;

  logic                               r_rd_vld;
  logic [DATA_WIDTH-1:0]              r_rd_data, w_rd_data;
  logic [1:0]                         r_rd_resp, w_rd_resp;
  logic                               w_rd_rdy;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bmask
    assign w_bmask[b] = bus.wr_strb[b/8];
  end

  // Ready is gated by rst_n directly so both channels come up the cycle reset drops.
  assign w_wr_acc = bus.wr_valid && (r_wr_state == S_IDLE) && i_rst_n;

  always_comb begin
    w_wr_sel  = '0;
    w_wr_resp = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.wr_addr == ADDR_WIDTH'(i)) begin
        w_wr_sel[i] = 1'b1;
        w_wr_resp   = RO_MASK[i] ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_wr_state_nxt    = r_wr_state;
    bus.wr_ready      = 1'b0;
    bus.wr_resp_valid = 1'b0;
    case (r_wr_state)
      S_IDLE: begin
        bus.wr_ready = i_rst_n;
        if (w_wr_acc) w_wr_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.wr_resp_valid = 1'b1;
        if (bus.wr_resp_ready) w_wr_state_nxt = S_IDLE;
      end
      default: w_wr_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= S_IDLE;
      r_wr_resp  <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if (w_wr_acc) r_wr_resp <= w_wr_resp;
    end
  end

  assign bus.wr_resp = r_wr_resp;

  // Event set is applied after the write clear so a same-cycle set wins.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regs_nxt[i] = r_regs[i];
      if (w_wr_acc && w_wr_sel[i]) begin
        if (W1C_MASK[i]) w_regs_nxt[i] = r_regs[i] & ~(bus.wr_data & w_bmask);
        else             w_regs_nxt[i] = (r_regs[i] & ~w_bmask) | (bus.wr_data & w_bmask);
      end
      if (W1C_MASK[i]) w_regs_nxt[i] = w_regs_nxt[i] | i_hw_in[i];
      if (RO_MASK[i])  w_regs_nxt[i] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_regs <= '0;
    else          r_regs <= w_regs_nxt;
  end

  assign o_regs_out = r_regs;

  // Read mux sees pre-edge storage, so a same-cycle write or event is not visible.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == ADDR_WIDTH'(i)) begin
        w_rd_resp = RESP_OKAY;
        w_rd_data = RO_MASK[i] ? i_hw_in[i] : r_regs[i];
      end
    end
  end

  assign w_rd_rdy     = i_rst_n && (!r_rd_vld || bus.rd_data_ready);
  assign bus.rd_ready = w_rd_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
      r_rd_resp <= RESP_OKAY;
    end else if (w_rd_rdy) begin
      r_rd_vld <= bus.rd_valid;
      if (bus.rd_valid) begin
        r_rd_data <= w_rd_data;
        r_rd_resp <= w_rd_resp;
      end
    end
  end

  assign bus.rd_data_valid = r_rd_vld;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_resp       = r_rd_resp;

endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank: reg 1 read-only, reg 2 write-1-to-clear, the rest RW.
module tb_csr_bank;
  localparam logic [15:0] RO  = 16'h0002;
  localparam logic [15:0] W1C = 16'h0004;

  logic clk, rst_n;
  logic [15:0][31:0] hw_in, regs_out, mdl;
  logic [1:0]  wq[$];
  logic [33:0] rq[$];
  int total, bad;

  csr_bank_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus();

  csr_bank #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(6), .RO_MASK(RO), .W1C_MASK(W1C)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_hw_in(hw_in), .o_regs_out(regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [33:0] exp_rd(input int a);
    if (a >= 16) return {2'b11, 32'h0};
    if (RO[a]) return {2'b00, hw_in[a]};
    return {2'b00, mdl[a]};
  endfunction

  task automatic wr_txn(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s; bus.wr_resp_ready = 1;
    n = 0; #1;
    while (!bus.wr_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1 bus.wr_valid = 0;
    while (!bus.wr_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    resp = bus.wr_resp;
    if (n >= 50) begin total++; bad++; $display("FAIL wr_timeout got=%0d exp=<50", n); end
    @(posedge clk); #1;
  endtask

  task automatic rd_txn(input logic [5:0] a, output logic [33:0] rv);
    int n;
    @(negedge clk);
    bus.rd_valid = 1; bus.rd_addr = a; bus.rd_data_ready = 1;
    n = 0; #1;
    while (!bus.rd_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1 bus.rd_valid = 0;
    while (!bus.rd_data_valid && n < 50) begin @(posedge clk); #1; n++; end
    rv = {bus.rd_resp, bus.rd_data};
    if (n >= 50) begin total++; bad++; $display("FAIL rd_timeout got=%0d exp=<50", n); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [33:0] rv, e;
    #3;
    total++; if (bus.wr_ready !== 0 || bus.rd_ready !== 0) begin bad++; $display("FAIL rst_ready got=%b%b exp=00", bus.wr_ready, bus.rd_ready); end
    total++; if (bus.wr_resp_valid !== 0 || bus.wr_resp !== 0) begin bad++; $display("FAIL rst_wresp got=%b/%b exp=0/00", bus.wr_resp_valid, bus.wr_resp); end
    total++; if (bus.rd_data_valid !== 0 || bus.rd_data !== 0 || bus.rd_resp !== 0) begin bad++; $display("FAIL rst_rd got=%b/%h/%b exp=0/0/00", bus.rd_data_valid, bus.rd_data, bus.rd_resp); end
    total++; if (regs_out !== '0) begin bad++; $display("FAIL rst_regs got=%h exp=0", regs_out); end
    @(negedge clk); rst_n = 1; #1;
    total++; if (bus.wr_ready !== 1 || bus.rd_ready !== 1) begin bad++; $display("FAIL post_rst_ready got=%b%b exp=11", bus.wr_ready, bus.rd_ready); end
    // park in RESP, then reset mid-response
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 0; bus.wr_data = 32'hDEADBEEF; bus.wr_strb = 4'hF; bus.wr_resp_ready = 0;
    @(posedge clk); #1 bus.wr_valid = 0;
    @(negedge clk);
    total++; if (bus.wr_resp_valid !== 1 || regs_out[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL resp_state got=%b/%h exp=1/deadbeef", bus.wr_resp_valid, regs_out[0]); end
    #2 rst_n = 0; #1;
    total++; if (bus.wr_resp_valid !== 0 || regs_out !== '0) begin bad++; $display("FAIL rst_mid got=%b/%h exp=0/0", bus.wr_resp_valid, regs_out[0]); end
    @(negedge clk); rst_n = 1; bus.wr_resp_ready = 1;
    rq.push_back(exp_rd(0)); rd_txn(0, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL rst_read got=%h exp=%h", rv, e); end
    total++; if (bus.wr_resp_valid !== 0) begin bad++; $display("FAIL rst_noresp got=%b exp=0", bus.wr_resp_valid); end
  endtask

  task automatic test_strobe;
    logic [1:0] r, we; logic [33:0] rv, e;
    wq.push_back(2'b00); wr_txn(3, 32'h11223344, 4'hF, r); mdl[3] = 32'h11223344; we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL strb_full_resp got=%b exp=%b", r, we); end
    wq.push_back(2'b00); wr_txn(3, 32'hAABBCCDD, 4'b0101, r); mdl[3] = 32'h11BB33DD; we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL strb_part_resp got=%b exp=%b", r, we); end
    wq.push_back(2'b00); wr_txn(3, 32'hFFFFFFFF, 4'b0000, r); we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL strb_zero_resp got=%b exp=%b", r, we); end
    rq.push_back(exp_rd(3)); rd_txn(3, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL strb_read got=%h exp=%h", rv, e); end
    total++; if (regs_out[3] !== 32'h11BB33DD) begin bad++; $display("FAIL strb_regs_out got=%h exp=11bb33dd", regs_out[3]); end
  endtask

  task automatic test_errors;
    logic [1:0] r, we; logic [33:0] rv, e;
    wq.push_back(2'b11); wr_txn(20, 32'hFFFFFFFF, 4'hF, r); we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL dec_wr_resp got=%b exp=%b", r, we); end
    wq.push_back(2'b10); wr_txn(1, 32'hFFFFFFFF, 4'hF, r); we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL ro_wr_resp got=%b exp=%b", r, we); end
    total++; if (regs_out !== mdl) begin bad++; $display("FAIL err_regs got=%h exp=%h", regs_out, mdl); end
    rq.push_back(exp_rd(20)); rd_txn(20, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL dec_rd got=%h exp=%h", rv, e); end
    hw_in[1] = 32'hCAFE0001;
    rq.push_back(exp_rd(1)); rd_txn(1, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL ro_rd got=%h exp=%h", rv, e); end
  endtask

  task automatic test_w1c;
    logic [1:0] r, we; logic [33:0] rv, e;
    @(negedge clk); hw_in[2] = 32'h11;
    @(negedge clk); hw_in[2] = 0; mdl[2] = 32'h11;
    rq.push_back(exp_rd(2)); rd_txn(2, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL w1c_set got=%h exp=%h", rv, e); end
    wq.push_back(2'b00); wr_txn(2, 32'h01, 4'b0001, r); mdl[2] = 32'h10; we = wq.pop_front();
    total++; if (r !== we) begin bad++; $display("FAIL w1c_clr_resp got=%b exp=%b", r, we); end
    rq.push_back(exp_rd(2)); rd_txn(2, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL w1c_clr got=%h exp=%h", rv, e); end
    // set and clear of bit 4 on the same edge
    @(negedge clk);
    hw_in[2] = 32'h10; bus.wr_valid = 1; bus.wr_addr = 2; bus.wr_data = 32'h10; bus.wr_strb = 4'b0001; bus.wr_resp_ready = 1;
    wq.push_back(2'b00);
    @(posedge clk); #1 hw_in[2] = 0; bus.wr_valid = 0; we = wq.pop_front();
    total++; if (bus.wr_resp_valid !== 1 || bus.wr_resp !== we) begin bad++; $display("FAIL w1c_race_resp got=%b/%b exp=1/%b", bus.wr_resp_valid, bus.wr_resp, we); end
    @(posedge clk); #1;
    rq.push_back(exp_rd(2)); rd_txn(2, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL w1c_race got=%h exp=%h", rv, e); end
  endtask

  task automatic test_backpressure;
    logic [33:0] e; logic [1:0] we;
    @(negedge clk); bus.rd_valid = 1; bus.rd_addr = 3; bus.rd_data_ready = 0; rq.push_back(exp_rd(3));
    @(posedge clk); #1 bus.rd_addr = 1; rq.push_back(exp_rd(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.rd_data_valid !== 1 || {bus.rd_resp, bus.rd_data} !== rq[0] || bus.rd_ready !== 0) begin
        bad++; $display("FAIL rd_hold got=%b/%h/%b exp=1/%h/0", bus.rd_data_valid, bus.rd_data, bus.rd_ready, rq[0]); end
    end
    @(negedge clk); bus.rd_data_ready = 1; e = rq.pop_front();
    total++; if ({bus.rd_resp, bus.rd_data} !== e) begin bad++; $display("FAIL rd_hold_last got=%h exp=%h", {bus.rd_resp, bus.rd_data}, e); end
    @(posedge clk); #1 bus.rd_valid = 0;
    @(negedge clk); e = rq.pop_front();
    total++; if (bus.rd_data_valid !== 1 || {bus.rd_resp, bus.rd_data} !== e) begin bad++; $display("FAIL rd_release got=%b/%h exp=1/%h", bus.rd_data_valid, {bus.rd_resp, bus.rd_data}, e); end
    @(posedge clk); #1;
    // write side: hold the response, keep a second write pending
    @(negedge clk); bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 32'h55; bus.wr_strb = 4'hF; bus.wr_resp_ready = 0; wq.push_back(2'b00);
    @(posedge clk); #1 bus.wr_addr = 6; bus.wr_data = 32'h66; mdl[5] = 32'h55; wq.push_back(2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.wr_ready !== 0 || bus.wr_resp_valid !== 1 || regs_out[6] !== mdl[6]) begin
        bad++; $display("FAIL wr_hold got=%b/%b/%h exp=0/1/%h", bus.wr_ready, bus.wr_resp_valid, regs_out[6], mdl[6]); end
    end
    @(negedge clk); we = wq.pop_front(); bus.wr_resp_ready = 1;
    total++; if (bus.wr_resp !== we) begin bad++; $display("FAIL wr_hold_resp got=%b exp=%b", bus.wr_resp, we); end
    @(posedge clk); #1;
    total++; if (bus.wr_ready !== 1) begin bad++; $display("FAIL wr_release_ready got=%b exp=1", bus.wr_ready); end
    @(posedge clk); #1 bus.wr_valid = 0; mdl[6] = 32'h66; we = wq.pop_front();
    total++; if (bus.wr_resp_valid !== 1 || bus.wr_resp !== we) begin bad++; $display("FAIL wr_second got=%b/%b exp=1/%b", bus.wr_resp_valid, bus.wr_resp, we); end
    @(posedge clk); #1;
    total++; if (regs_out !== mdl) begin bad++; $display("FAIL bp_regs got=%h exp=%h", regs_out, mdl); end
  endtask

  task automatic test_collision;
    logic [33:0] rv, e; logic [1:0] we;
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 32'h5A5A; bus.wr_strb = 4'hF; bus.wr_resp_ready = 1;
    bus.rd_valid = 1; bus.rd_addr = 5; bus.rd_data_ready = 1;
    rq.push_back(exp_rd(5)); wq.push_back(2'b00);
    @(posedge clk); #1 bus.wr_valid = 0; bus.rd_valid = 0; mdl[5] = 32'h5A5A;
    e = rq.pop_front(); we = wq.pop_front();
    total++; if (bus.rd_data_valid !== 1 || {bus.rd_resp, bus.rd_data} !== e) begin bad++; $display("FAIL coll_rd got=%h exp=%h", {bus.rd_resp, bus.rd_data}, e); end
    total++; if (bus.wr_resp_valid !== 1 || bus.wr_resp !== we) begin bad++; $display("FAIL coll_wr got=%b exp=%b", bus.wr_resp, we); end
    @(posedge clk); #1;
    rq.push_back(exp_rd(5)); rd_txn(5, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL coll_after got=%h exp=%h", rv, e); end
    // event arriving with the read stays invisible to it
    @(negedge clk); bus.rd_valid = 1; bus.rd_addr = 2; hw_in[2] = 32'h1; rq.push_back(exp_rd(2));
    @(posedge clk); #1 bus.rd_valid = 0; hw_in[2] = 0; mdl[2] = mdl[2] | 32'h1; e = rq.pop_front();
    total++; if ({bus.rd_resp, bus.rd_data} !== e) begin bad++; $display("FAIL coll_evt got=%h exp=%h", {bus.rd_resp, bus.rd_data}, e); end
    @(posedge clk); #1;
    rq.push_back(exp_rd(2)); rd_txn(2, rv); e = rq.pop_front();
    total++; if (rv !== e) begin bad++; $display("FAIL coll_evt_after got=%h exp=%h", rv, e); end
  endtask

  task automatic test_back_to_back;
    logic [33:0] e;
    bus.rd_data_ready = 1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = rq.pop_front();
        total++; if (bus.rd_data_valid !== 1 || {bus.rd_resp, bus.rd_data} !== e) begin
          bad++; $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", k-1, bus.rd_data_valid, {bus.rd_resp, bus.rd_data}, e); end
      end
      if (k < 8) begin
        bus.rd_valid = 1; bus.rd_addr = 6'(k); rq.push_back(exp_rd(k)); #1;
        total++; if (bus.rd_ready !== 1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, bus.rd_ready); end
      end else bus.rd_valid = 0;
    end
    @(negedge clk);
    total++; if (bus.rd_data_valid !== 0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.rd_data_valid); end
  endtask

  initial begin
    total = 0; bad = 0; rst_n = 0; hw_in = '0; mdl = '0;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_strb = 0; bus.wr_resp_ready = 0;
    bus.rd_valid = 0; bus.rd_addr = 0; bus.rd_data_ready = 0;
    test_reset;
    test_strobe;
    test_errors;
    test_w1c;
    test_backpressure;
    test_collision;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
